// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU memory bus. Every rising edge the bus
//   command is decoded into a RAM access, an LED register write, a switch read
//   or a bus error. Read data comes back through a fixed-latency pipeline and
//   is flagged by a one-cycle r_valid pulse. The RAM (program/data store) and
//   the LED/switch I/O live here.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous reset, active low
//   mem_cmd   in   2   bus command (MNONE / MREAD / MWRITE, 2'b11 is illegal)
//   mem_addr  in   9   word address
//   w_data    in   16  write data, qualified by MWRITE
//   r_data    out  16  read data; holds the last returned word between reads
//   r_valid   out  1   one-cycle pulse per completed read
//   sw        in   8   board switches, asynchronous to clk
//   led       out  8   LED register
//   err       out  1   sticky bus-error flag, cleared only by reset
//
// Address map
//   0x000..RAM_WORDS-1  RAM, read/write
//   0x100               LED register (write led<=w_data[7:0], read {8'h00,led})
//   0x140               switches, read-only ({8'h00,sw_sync})
//   anything else       unmapped: reads return zero, any access sets err
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int         RAM_WORDS = 256,   // 2..256
   parameter int         READ_LAT  = 1,     // 1..4
   parameter string      INIT_FILE = "",
   parameter logic [1:0] MNONE     = 2'b00,
   parameter logic [1:0] MREAD     = 2'b01,
   parameter logic [1:0] MWRITE    = 2'b10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mem_cmd,
   input  logic [8:0]  mem_addr,
   input  logic [15:0] w_data,
   output logic [15:0] r_data,
   output logic        r_valid,
   input  logic [7:0]  sw,
   output logic [7:0]  led,
   output logic        err
);

   localparam int         AW       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [9:0] RAM_LIM  = 10'(RAM_WORDS);
   localparam logic [8:0] LED_ADDR = 9'h100;
   localparam logic [8:0] SW_ADDR  = 9'h140;

   logic [15:0]         ram [RAM_WORDS];
   logic [7:0]          sw_meta;
   logic [7:0]          sw_sync;
   logic                is_rd;
   logic                is_wr;
   logic                bad_cmd;
   logic                hit_ram;
   logic                hit_led;
   logic                hit_sw;
   logic                err_set;
   logic                ram_we;
   logic [15:0]         rd_data_p0;
   logic [15:0]         data_pn [READ_LAT];
   logic [READ_LAT-1:0] vld_pn;

   // Command and address decode
   always_comb begin
      is_rd   = 1'b0;
      is_wr   = 1'b0;
      bad_cmd = 1'b0;
      case (mem_cmd)
         MNONE:   ;
         MREAD:   is_rd   = 1'b1;
         MWRITE:  is_wr   = 1'b1;
         default: bad_cmd = 1'b1;
      endcase
   end

   // Addresses 0x000..0x0FF above RAM_WORDS fall out of hit_ram and are unmapped.
   assign hit_ram = ({1'b0, mem_addr} < RAM_LIM);
   assign hit_led = (mem_addr == LED_ADDR);
   assign hit_sw  = (mem_addr == SW_ADDR);

   assign err_set = bad_cmd
                  | (is_wr & ~(hit_ram | hit_led))
                  | (is_rd & ~(hit_ram | hit_led | hit_sw));

   assign ram_we = is_wr & hit_ram;

   // Read data as seen at the command edge; unmapped reads return zero.
   // The RAM read is combinational, so a read one edge after a write
   // already sees the freshly written word.
   always_comb begin
      rd_data_p0 = 16'h0000;
      if (hit_ram) begin
         rd_data_p0 = ram[mem_addr[AW-1:0]];
      end else if (hit_led) begin
         rd_data_p0 = {8'h00, led};
      end else if (hit_sw) begin
         rd_data_p0 = {8'h00, sw_sync};
      end
   end

   // RAM has no reset so its contents survive a reset pulse; writes are
   // ignored while reset is held.
   always_ff @(posedge clk) begin
      if (reset && ram_we) begin
         ram[mem_addr[AW-1:0]] <= w_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
         led     <= '0;
         err     <= 1'b0;
         vld_pn  <= '0;
         for (int k = 0; k < READ_LAT; k++) begin
            data_pn[k] <= '0;
         end
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;

         if (is_wr && hit_led) begin
            led <= w_data[7:0];
         end
         if (err_set) begin
            err <= 1'b1;
         end

         // p0 -> stage 0: capture decoded read data at the command edge
         vld_pn[0] <= is_rd;
         if (is_rd) begin
            data_pn[0] <= rd_data_p0;
         end

         // stage k-1 -> stage k: data only moves with a valid read, so the
         // last stage keeps the most recent returned word between reads
         for (int k = 1; k < READ_LAT; k++) begin
            vld_pn[k] <= vld_pn[k-1];
            if (vld_pn[k-1]) begin
               data_pn[k] <= data_pn[k-1];
            end
         end
      end
   end

   // last stage -> bus outputs
   assign r_valid = vld_pn[READ_LAT-1];
   assign r_data  = data_pn[READ_LAT-1];

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Drives two responders in parallel from one bus: dut1 (READ_LAT=1,
//   RAM_WORDS=256) and dut3 (READ_LAT=3, RAM_WORDS=192). A behavioural model
//   tracks memory contents, LED, error flag and a read-return schedule per
//   instance; every cycle the outputs of both instances are compared with it.
//   Directed sequences add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   localparam logic [1:0] C_NONE  = 2'b00;
   localparam logic [1:0] C_READ  = 2'b01;
   localparam logic [1:0] C_WRITE = 2'b10;
   localparam logic [1:0] C_BAD   = 2'b11;

   logic        clk;
   logic        reset;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] w_data;
   logic [7:0]  sw;

   logic [15:0] r_data1, r_data3;
   logic        r_valid1, r_valid3;
   logic [7:0]  led1, led3;
   logic        err1, err3;

   int checks = 0;
   int errors = 0;

   mem_responder #(.RAM_WORDS(256), .READ_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .w_data(w_data), .r_data(r_data1), .r_valid(r_valid1), .sw(sw),
      .led(led1), .err(err1)
   );

   mem_responder #(.RAM_WORDS(192), .READ_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .w_data(w_data), .r_data(r_data3), .r_valid(r_valid3), .sw(sw),
      .led(led3), .err(err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   logic [15:0] mem_m  [2][512];
   logic        slot_v [2][8];
   logic [15:0] slot_d [2][8];
   logic [7:0]  m_led  [2];
   logic        m_err  [2];
   logic        m_rv   [2];
   logic [15:0] m_rd   [2];
   logic [7:0]  sw_h1  [2];   // sw seen at the previous edge
   logic [7:0]  sw_h2  [2];   // sw seen two edges ago
   int          cyc_n = 0;

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int words_of(input int d);
      return (d == 0) ? 256 : 192;
   endfunction

   task automatic model_edge(input int d);
      logic [15:0] rd;
      int a;
      int s;
      if (!reset) begin
         for (int i = 0; i < 8; i++) slot_v[d][i] = 1'b0;
         m_led[d] = 8'h00;
         m_err[d] = 1'b0;
         m_rv[d]  = 1'b0;
         m_rd[d]  = 16'h0000;
         sw_h1[d] = 8'h00;
         sw_h2[d] = 8'h00;
         return;
      end
      a  = int'(mem_addr);
      rd = 16'h0000;
      if (mem_cmd == C_BAD) begin
         m_err[d] = 1'b1;
      end else if (mem_cmd == C_WRITE) begin
         if (a < words_of(d))  mem_m[d][a] = w_data;
         else if (a == 'h100)  m_led[d] = w_data[7:0];
         else                  m_err[d] = 1'b1;
      end else if (mem_cmd == C_READ) begin
         if (a < words_of(d))  rd = mem_m[d][a];
         else if (a == 'h100)  rd = {8'h00, m_led[d]};
         else if (a == 'h140)  rd = {8'h00, sw_h2[d]};
         else                  m_err[d] = 1'b1;
         // data is due in the cycle after edge (this + READ_LAT - 1)
         s = (cyc_n + lat_of(d) - 1) % 8;
         slot_v[d][s] = 1'b1;
         slot_d[d][s] = rd;
      end
      sw_h2[d] = sw_h1[d];
      sw_h1[d] = sw;
      s = cyc_n % 8;
      if (slot_v[d][s]) begin
         m_rv[d] = 1'b1;
         m_rd[d] = slot_d[d][s];
         slot_v[d][s] = 1'b0;
      end else begin
         m_rv[d] = 1'b0;
      end
   endtask

   logic [15:0] log1_d[$];
   logic [15:0] log3_d[$];
   int          log3_c[$];

   // Model update at each edge, then compare both instances after settling.
   always @(posedge clk) begin
      cyc_n++;
      model_edge(0);
      model_edge(1);
      #2;
      chk("r_valid1", {15'h0, r_valid1}, {15'h0, m_rv[0]});
      chk("r_data1",  r_data1,           m_rd[0]);
      chk("led1",     {8'h0, led1},      {8'h0, m_led[0]});
      chk("err1",     {15'h0, err1},     {15'h0, m_err[0]});
      chk("r_valid3", {15'h0, r_valid3}, {15'h0, m_rv[1]});
      chk("r_data3",  r_data3,           m_rd[1]);
      chk("led3",     {8'h0, led3},      {8'h0, m_led[1]});
      chk("err3",     {15'h0, err3},     {15'h0, m_err[1]});
      if (r_valid1) log1_d.push_back(r_data1);
      if (r_valid3) begin
         log3_d.push_back(r_data3);
         log3_c.push_back(cyc_n);
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
      @(negedge clk);
      mem_cmd  = c;
      mem_addr = a;
      w_data   = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(C_NONE, 9'h000, 16'h0000);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #3;
   endtask

   function automatic logic [15:0] qat(input logic [15:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 16'hDEAD;
   endfunction

   task automatic clear_logs();
      log1_d.delete();
      log3_d.delete();
      log3_c.delete();
   endtask

   initial begin
      reset    = 1'b0;
      mem_cmd  = C_READ;
      mem_addr = 9'h000;
      w_data   = 16'h0000;
      sw       = 8'h00;

      // T1: reads presented while reset is held
      repeat (3) @(posedge clk);
      #3;
      chk("t1_rvalid1", {15'h0, r_valid1}, 16'h0000);
      chk("t1_rdata1",  r_data1,           16'h0000);
      chk("t1_led1",    {8'h0, led1},      16'h0000);
      chk("t1_err1",    {15'h0, err1},     16'h0000);
      chk("t1_rvalid3", {15'h0, r_valid3}, 16'h0000);
      chk("t1_err3",    {15'h0, err3},     16'h0000);
      @(negedge clk);
      mem_cmd = C_NONE;
      reset   = 1'b1;
      idle(2);

      // T2: write then immediate read-back
      clear_logs();
      drive(C_WRITE, 9'h005, 16'hABCD);
      drive(C_READ,  9'h005, 16'h0000);
      after_edge();
      chk("t2_rvalid1_hi", {15'h0, r_valid1}, 16'h0001);
      chk("t2_rdata1",     r_data1,           16'hABCD);
      drive(C_NONE, 9'h000, 16'h0000);
      after_edge();
      chk("t2_rvalid1_lo", {15'h0, r_valid1}, 16'h0000);
      chk("t2_rdata1_hold", r_data1,          16'hABCD);
      idle(4);
      chk("t2_log3_len", 16'(log3_d.size()), 16'd1);
      chk("t2_log3_0",   qat(log3_d, 0),     16'hABCD);

      // T3: back-to-back reads through the deep pipeline
      drive(C_WRITE, 9'h000, 16'h0001);
      drive(C_WRITE, 9'h001, 16'h0002);
      drive(C_WRITE, 9'h002, 16'h0003);
      clear_logs();
      drive(C_READ, 9'h000, 16'h0000);
      drive(C_READ, 9'h001, 16'h0000);
      drive(C_READ, 9'h002, 16'h0000);
      idle(6);
      chk("t3_log3_len", 16'(log3_d.size()), 16'd3);
      chk("t3_log3_0",   qat(log3_d, 0),     16'h0001);
      chk("t3_log3_1",   qat(log3_d, 1),     16'h0002);
      chk("t3_log3_2",   qat(log3_d, 2),     16'h0003);
      chk("t3_span", (log3_c.size() == 3) ? 16'(log3_c[2] - log3_c[0]) : 16'hFFFF, 16'd2);
      chk("t3_log1_2",   qat(log1_d, 2),     16'h0003);

      // T4: LED register and synchronised switches
      clear_logs();
      sw = 8'h3C;
      drive(C_WRITE, 9'h100, 16'h12A5);
      after_edge();
      chk("t4_led1", {8'h0, led1}, 16'h00A5);
      chk("t4_led3", {8'h0, led3}, 16'h00A5);
      drive(C_READ, 9'h100, 16'h0000);
      idle(3);
      drive(C_READ, 9'h140, 16'h0000);
      idle(4);
      chk("t4_log1_led", qat(log1_d, 0), 16'h00A5);
      chk("t4_log1_sw",  qat(log1_d, 1), 16'h003C);
      chk("t4_log3_led", qat(log3_d, 0), 16'h00A5);
      chk("t4_log3_sw",  qat(log3_d, 1), 16'h003C);
      chk("t4_err1",     {15'h0, err1},  16'h0000);

      // Address past a 192-word RAM but inside 0x000..0x0FF
      clear_logs();
      drive(C_WRITE, 9'h0C0, 16'h5555);
      drive(C_READ,  9'h0C0, 16'h0000);
      idle(4);
      chk("hole_log1", qat(log1_d, 0), 16'h5555);
      chk("hole_log3", qat(log3_d, 0), 16'h0000);
      chk("hole_err1", {15'h0, err1},  16'h0000);
      chk("hole_err3", {15'h0, err3},  16'h0001);

      // T5: illegal command, write to switches, unmapped read/write
      clear_logs();
      drive(C_BAD, 9'h005, 16'hFFFF);
      after_edge();
      chk("t5_err1_set", {15'h0, err1}, 16'h0001);
      drive(C_WRITE, 9'h140, 16'hFFFF);
      drive(C_READ,  9'h1FF, 16'h0000);
      drive(C_WRITE, 9'h1FF, 16'hFFFF);
      drive(C_READ,  9'h005, 16'h0000);
      idle(4);
      chk("t5_err1",    {15'h0, err1}, 16'h0001);
      chk("t5_err3",    {15'h0, err3}, 16'h0001);
      chk("t5_led1",    {8'h0, led1},  16'h00A5);
      chk("t5_log1_uA", qat(log1_d, 0), 16'h0000);
      chk("t5_log1_ram", qat(log1_d, 1), 16'hABCD);
      chk("t5_log3_uA", qat(log3_d, 0), 16'h0000);
      chk("t5_log3_ram", qat(log3_d, 1), 16'hABCD);

      // T6: reset while a deep-pipeline read is in flight
      drive(C_READ, 9'h005, 16'h0000);
      drive(C_NONE, 9'h000, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      clear_logs();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idle(5);
      chk("t6_log3_len", 16'(log3_d.size()), 16'd0);
      chk("t6_err3",     {15'h0, err3},      16'h0000);
      chk("t6_led3",     {8'h0, led3},       16'h0000);
      chk("t6_rdata3",   r_data3,            16'h0000);
      drive(C_READ, 9'h005, 16'h0000);
      idle(4);
      chk("t6_log3_len2", 16'(log3_d.size()), 16'd1);
      chk("t6_log3_0",    qat(log3_d, 0),     16'hABCD);
      chk("t6_log1_0",    qat(log1_d, 0),     16'hABCD);

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
